// File: rtl/mem_io_responder_if.sv
// Byte-wide CPU memory bus between the cpu (master) and the memory/I-O responder (slave).
interface mem_io_responder_if;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        io_buffer_full;

    modport master (
        output mem_a,
        output mem_wr,
        output mem_dout,
        input  mem_din,
        input  io_buffer_full
    );

    modport slave (
        input  mem_a,
        input  mem_wr,
        input  mem_dout,
        output mem_din,
        output io_buffer_full
    );
endinterface

// File: rtl/mem_io_responder.sv
// Responder end of the cpu byte bus.
// Provides a byte RAM with one-cycle read latency.
// I/O lives where mem_a[17:16] == 2'b11. It holds the UART TX FIFO, the RX holding byte,
// a free-running cycle counter with a read snapshot, and a sticky program-stop flag.
module mem_io_responder #(
    parameter int ADDR_W      = 17,
    parameter int TXQ_DEPTH   = 8,
    parameter int FULL_MARGIN = 2
) (
    input  logic                clk_in,
    input  logic                rst_in,
    mem_io_responder_if.slave   bus,
    output logic                tx_valid,
    output logic [7:0]          tx_data,
    input  logic                tx_ready,
    input  logic                rx_valid,
    input  logic [7:0]          rx_data,
    output logic                rx_ready,
    output logic                prog_stop
);

    localparam int PTR_W = $clog2(TXQ_DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT  = (PTR_W+1)'(TXQ_DEPTH);
    localparam logic [PTR_W:0] FULL_LEVEL = (PTR_W+1)'(TXQ_DEPTH - FULL_MARGIN);

    logic [7:0]        ram [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] ram_idx;
    logic              is_io;
    logic [15:0]       io_off;
    logic              io_rd;
    logic              io_wr;
    logic              push_req;
    logic [7:0]        push_byte;
    logic              push_ok;
    logic              pop;
    logic              fifo_full;
    logic              rd_rx;
    logic [7:0]        io_rdata;

    logic [31:0]       cycle_cnt;
    logic [31:0]       snapshot;
    logic              rx_full;
    logic [7:0]        rx_byte;

    logic [7:0]        fifo_mem [0:TXQ_DEPTH-1];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic [PTR_W:0]    next_count;

    logic              unused_addr_bits;

    // Upper address bits carry no meaning for this responder.
    assign unused_addr_bits = ^bus.mem_a[31:18];

    assign is_io     = (bus.mem_a[17:16] == 2'b11);
    assign io_off    = bus.mem_a[15:0];
    assign ram_idx   = bus.mem_a[ADDR_W-1:0];
    assign io_rd     = is_io && !bus.mem_wr;
    assign io_wr     = is_io && bus.mem_wr;
    assign rd_rx     = io_rd && (io_off == 16'h0000);

    // A zero written to the TX port is dropped, while the stop write always queues a zero.
    assign push_req  = (io_wr && (io_off == 16'h0000) && (bus.mem_dout != 8'h00)) ||
                       (io_wr && (io_off == 16'h0004));
    assign push_byte = (io_off == 16'h0004) ? 8'h00 : bus.mem_dout;

    assign fifo_full = (count == DEPTH_CNT);
    assign tx_valid  = (count != '0);
    assign tx_data   = fifo_mem[rd_ptr];
    assign pop       = tx_valid && tx_ready;
    assign push_ok   = push_req && (!fifo_full || pop);
    assign rx_ready  = !rx_full;

    // TX occupancy after this edge; io_buffer_full is registered from it.
    always_comb begin
        next_count = count;
        if (push_ok && !pop) begin
            next_count = count + 1'b1;
        end else if (!push_ok && pop) begin
            next_count = count - 1'b1;
        end
    end

    // Read data for the I/O window; byte 4 returns live counter, 5..7 the snapshot.
    always_comb begin
        io_rdata = 8'h00;
        case (io_off)
            16'h0000: io_rdata = rx_full ? rx_byte : 8'h00;
            16'h0004: io_rdata = cycle_cnt[7:0];
            16'h0005: io_rdata = snapshot[15:8];
            16'h0006: io_rdata = snapshot[23:16];
            16'h0007: io_rdata = snapshot[31:24];
            default:  io_rdata = 8'h00;
        endcase
    end

    // RAM write port; contents deliberately survive reset.
    always_ff @(posedge clk_in) begin
        if (bus.mem_wr && !is_io) begin
            ram[ram_idx] <= bus.mem_dout;
        end
    end

    // Read data register: updated on every read cycle, held across write cycles.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            bus.mem_din <= 8'h00;
        end else if (!bus.mem_wr) begin
            bus.mem_din <= is_io ? io_rdata : ram[ram_idx];
        end
    end

    // Free-running cycle counter and snapshot captured when the low byte is read.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cycle_cnt <= 32'h0;
            snapshot  <= 32'h0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'h1;
            if (io_rd && (io_off == 16'h0004)) begin
                snapshot <= cycle_cnt;
            end
        end
    end

    // RX holding register: latch only when empty, consumed by a read of the RX port.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rx_full <= 1'b0;
            rx_byte <= 8'h00;
        end else if (rd_rx && rx_full) begin
            rx_full <= 1'b0;
        end else if (rx_valid && !rx_full) begin
            rx_full <= 1'b1;
            rx_byte <= rx_data;
        end
    end

    // Sticky program-stop flag.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            prog_stop <= 1'b0;
        end else if (io_wr && (io_off == 16'h0004)) begin
            prog_stop <= 1'b1;
        end
    end

    // TX FIFO pointers, occupancy and early back-pressure flag.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            bus.io_buffer_full <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count              <= next_count;
            bus.io_buffer_full <= (next_count >= FULL_LEVEL);
        end
    end

    // TX FIFO storage; stale entries are unreachable after reset clears the pointers.
    always_ff @(posedge clk_in) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= push_byte;
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed self-checking bench for mem_io_responder.
module tb_mem_io_responder;

    logic       clk_in;
    logic       rst_in;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       prog_stop;

    int total;
    int bad;

    mem_io_responder_if bus_if ();

    mem_io_responder dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .bus       (bus_if.slave),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .prog_stop (prog_stop)
    );

    // 10 time-unit clock.
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Present one bus cycle, let the edge happen, then settle just past it.
    task automatic apply_stimulus(input logic [31:0] addr, input logic wr, input logic [7:0] data);
        bus_if.mem_a    = addr;
        bus_if.mem_wr   = wr;
        bus_if.mem_dout = data;
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            apply_stimulus(32'h0000_0000, 1'b0, 8'h00);
        end
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
            $error("[TB] %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_in          = 1'b0;
        tx_ready        = 1'b0;
        rx_valid        = 1'b0;
        rx_data         = 8'h00;
        bus_if.mem_a    = 32'h0;
        bus_if.mem_wr   = 1'b0;
        bus_if.mem_dout = 8'h00;

        // Reset state.
        repeat (3) @(posedge clk_in);
        #1;
        check_output("rst_mem_din", 32'(bus_if.mem_din), 32'h00);
        check_output("rst_tx_valid", 32'(tx_valid), 32'h0);
        check_output("rst_buf_full", 32'(bus_if.io_buffer_full), 32'h0);
        check_output("rst_rx_ready", 32'(rx_ready), 32'h1);
        check_output("rst_prog_stop", 32'(prog_stop), 32'h0);
        rst_in = 1'b1;

        // Counter: 100 edges after release, then read the counter bytes.
        idle(100);
        apply_stimulus(32'h0003_0004, 1'b0, 8'h00);
        check_output("cnt_byte0", 32'(bus_if.mem_din), 32'h64);
        apply_stimulus(32'h0003_0005, 1'b0, 8'h00);
        check_output("cnt_byte1", 32'(bus_if.mem_din), 32'h00);
        apply_stimulus(32'h0003_0006, 1'b0, 8'h00);
        check_output("cnt_byte2", 32'(bus_if.mem_din), 32'h00);
        apply_stimulus(32'h0003_0007, 1'b0, 8'h00);
        check_output("cnt_byte3", 32'(bus_if.mem_din), 32'h00);

        // RAM write/read; write cycles must not disturb mem_din.
        apply_stimulus(32'h0000_0123, 1'b1, 8'hA5);
        check_output("ram_wr_hold", 32'(bus_if.mem_din), 32'h00);
        apply_stimulus(32'h0000_0123, 1'b0, 8'h00);
        check_output("ram_rd_123", 32'(bus_if.mem_din), 32'hA5);
        apply_stimulus(32'h0000_0124, 1'b1, 8'h3C);
        check_output("ram_wr_hold2", 32'(bus_if.mem_din), 32'hA5);
        apply_stimulus(32'h0001_FFFF, 1'b1, 8'h5A);
        apply_stimulus(32'h0001_FFFF, 1'b0, 8'h00);
        check_output("ram_rd_top", 32'(bus_if.mem_din), 32'h5A);
        apply_stimulus(32'h0000_0124, 1'b0, 8'h00);
        check_output("ram_rd_124", 32'(bus_if.mem_din), 32'h3C);
        apply_stimulus(32'h0000_0123, 1'b0, 8'h00);
        check_output("ram_rd_123b", 32'(bus_if.mem_din), 32'hA5);

        // Unmapped io: reads zero, writes ignored.
        apply_stimulus(32'h0003_0008, 1'b0, 8'h00);
        check_output("io_other_rd", 32'(bus_if.mem_din), 32'h00);
        apply_stimulus(32'h0003_0010, 1'b1, 8'h77);
        check_output("io_other_wr", 32'(tx_valid), 32'h0);

        // TX "Hi\0" with tx_ready high; zero never emitted.
        tx_ready = 1'b1;
        apply_stimulus(32'h0003_0000, 1'b1, 8'h48);
        check_output("tx_H_valid", 32'(tx_valid), 32'h1);
        check_output("tx_H_data", 32'(tx_data), 32'h48);
        apply_stimulus(32'h0003_0000, 1'b1, 8'h69);
        check_output("tx_i_data", 32'(tx_data), 32'h69);
        apply_stimulus(32'h0003_0000, 1'b1, 8'h00);
        check_output("tx_zero_drop", 32'(tx_valid), 32'h0);

        // Fill with tx_ready low: back-pressure after 6th, 9th dropped.
        tx_ready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            apply_stimulus(32'h0003_0000, 1'b1, 8'(i));
            if (i == 5) check_output("buf_full_5", 32'(bus_if.io_buffer_full), 32'h0);
            if (i == 6) check_output("buf_full_6", 32'(bus_if.io_buffer_full), 32'h1);
        end
        check_output("full_head", 32'(tx_data), 32'h01);
        tx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check_output($sformatf("drain_valid_%0d", i), 32'(tx_valid), 32'h1);
            check_output($sformatf("drain_data_%0d", i), 32'(tx_data), 32'(i));
            idle(1);
        end
        check_output("drain_empty", 32'(tx_valid), 32'h0);
        check_output("drain_buf_full", 32'(bus_if.io_buffer_full), 32'h0);

        // Full FIFO with same-cycle pop accepts the push.
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(32'h0003_0000, 1'b1, 8'(8'h11 + i));
        end
        tx_ready = 1'b1;
        apply_stimulus(32'h0003_0000, 1'b1, 8'h77);
        check_output("fullpop_head", 32'(tx_data), 32'h12);
        check_output("fullpop_buf_full", 32'(bus_if.io_buffer_full), 32'h1);
        for (int i = 0; i < 7; i++) begin
            check_output($sformatf("fullpop_data_%0d", i), 32'(tx_data), 32'(8'h12 + i));
            idle(1);
        end
        check_output("fullpop_last", 32'(tx_data), 32'h77);
        idle(1);
        check_output("fullpop_empty", 32'(tx_valid), 32'h0);

        // RX holding register; second offer while full is not latched.
        rx_valid = 1'b1;
        rx_data  = 8'h41;
        idle(1);
        check_output("rx_ready_full", 32'(rx_ready), 32'h0);
        rx_data  = 8'h42;
        idle(1);
        rx_valid = 1'b0;
        apply_stimulus(32'h0003_0000, 1'b0, 8'h00);
        check_output("rx_read", 32'(bus_if.mem_din), 32'h41);
        check_output("rx_ready_free", 32'(rx_ready), 32'h1);
        apply_stimulus(32'h0003_0000, 1'b0, 8'h00);
        check_output("rx_reread", 32'(bus_if.mem_din), 32'h00);

        // Program stop emits 0x00 and sticks; async reset clears everything.
        tx_ready = 1'b0;
        check_output("stop_before", 32'(prog_stop), 32'h0);
        apply_stimulus(32'h0003_0004, 1'b1, 8'hFF);
        check_output("stop_set", 32'(prog_stop), 32'h1);
        check_output("stop_tx_valid", 32'(tx_valid), 32'h1);
        check_output("stop_tx_zero", 32'(tx_data), 32'h00);
        apply_stimulus(32'h0000_0123, 1'b0, 8'h00);
        check_output("stop_sticky", 32'(prog_stop), 32'h1);
        check_output("pre_rst_din", 32'(bus_if.mem_din), 32'hA5);
        #2;
        rst_in = 1'b0;
        #1;
        check_output("arst_prog_stop", 32'(prog_stop), 32'h0);
        check_output("arst_tx_valid", 32'(tx_valid), 32'h0);
        check_output("arst_mem_din", 32'(bus_if.mem_din), 32'h00);
        check_output("arst_rx_ready", 32'(rx_ready), 32'h1);
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
